sdram_frame_scheduler: RTL and testbench
========================================

// Module: sdram_frame_scheduler
// PURPOSE
// Sequences the shared SDRAM controller between the camera write FIFO (drain side) and the
// display read FIFO (fill side) in the sdram_clk domain. Issues 8-word bursts, generates
// frame addresses with wrap-around, and double-buffers frames: write and read buffers swap
// on frame boundaries. Read has priority; write gets a guaranteed grant after starvation.
// PARAMETERS
// VIDEO_END       153600    words per frame (640*480 RAW8, 2 px/word); multiple of BURST_LENGTH
// BURST_LENGTH    8         words per burst
// WRITE_PTR_W     6         write FIFO used-count width
// READ_PTR_W      5         read FIFO used-count width
// MAX_WRITE_WAIT  4         consecutive read grants allowed while a write is eligible
// BUFFER_STRIDE   22'h040000 word offset between frame buffer 0 and 1
// PORTS
// sdram_clk        in   1            clock
// reset_n          in   1            asynchronous, active-low reset
// write_used       in   WRITE_PTR_W  write FIFO fill level (words available)
// write_ack        out  1            pop one word from write FIFO
// read_used        in   READ_PTR_W   read FIFO fill level
// read_push        out  1            push data_read into read FIFO
// write_frame_start in  1            1-cycle pulse: camera frame begins (already synchronized)
// read_frame_start in   1            1-cycle pulse: display frame begins (already synchronized)
// command          out  2            0 idle, 1 write, 2 read (to controller)
// data_address     out  22           burst word address (to controller)
// data_read_valid  in   1            controller read beat valid
// data_write_done  in   1            controller write beat accepted
// write_buffer     out  1            buffer currently written
// read_buffer      out  1            buffer currently read
// BEHAVIOUR
// - Reset (async, any state): command=0, all offsets/counters=0, write_buffer=0,
//   read_buffer=0, last_complete=0, pending flags=0; write_ack/read_push low.
// - FSM IDLE/READ/WRITE; command = 0/2/1 registered. Decision in IDLE each cycle:
//   read_ok  = (2**READ_PTR_W-1 - read_used) >= BURST_LENGTH; write_ok = write_used >= BURST_LENGTH.
//   write_wait>=MAX_WRITE_WAIT && write_ok -> WRITE; else read_ok -> READ; else write_ok -> WRITE.
// - write_wait: +1 on READ grant while write_ok, cleared on WRITE grant; saturates.
// - READ: read_push = data_read_valid (combinational). Beat counter counts valids; on
//   BURST_LENGTH-th valid -> IDLE next cycle, read_offset += BURST_LENGTH.
// - WRITE: write_ack pulses in grant cycle (prefetch) and on each data_write_done except the
//   last -> exactly BURST_LENGTH acks/burst. BURST_LENGTH-th done -> IDLE, write_offset += BL.
// - data_address = offset + (buffer ? BUFFER_STRIDE : 0), stable whole burst; 0 in IDLE.
// - Offset reaching VIDEO_END wraps to 0 (22-bit compare on offset+BL). Write wrap = frame
//   complete: last_complete<=write_buffer, write_buffer<=~write_buffer. Read wrap:
//   read_buffer<=last_complete.
// - *_frame_start sets pending flag; applied in IDLE (immediately if idle, else at burst end):
//   offset<=0; write side counts as frame complete only if write_offset!=0 (short frame).
//   Pending reset overrides same-cycle increment/wrap. Pulse during pending: no extra effect.
// - No burst is ever aborted; min 1 IDLE cycle between bursts. Beat inputs in IDLE ignored.
// TESTING
// - Reset mid-WRITE (beat 3): command=0 asynchronously, offsets 0, no further write_ack.
// - read_used=0, write_used=40: READ, READ, READ, READ, then WRITE (MAX_WRITE_WAIT=4), READ.
// - write_used=8, read FIFO full (31): one WRITE burst, exactly 8 write_ack, addr 0 then 8.
// - 19200 write bursts: offset wraps 153592->0, write_buffer 0->1, next address 0x040000;
//   read wrap afterwards sets read_buffer=0 (last_complete).
// - write_frame_start at write_offset=64 mid-burst: burst finishes, next write address
//   = 0 in toggled buffer; same-cycle pulse at wrap yields single toggle.
// - data_read_valid gaps (1-of-3 cycles): exactly 8 read_push, READ holds, address stable.

Source files
------------

// File: rtl/sdram_frame_scheduler.sv
// Arbitrates 8-word SDRAM bursts between camera write and display read FIFOs with double-buffered frames.
// Grant is registered one cycle after the IDLE decision; bursts hold until their last beat, never aborted.
module sdram_frame_scheduler #(
  parameter int          VIDEO_END      = 153600,
  parameter int          BURST_LENGTH   = 8,
  parameter int          WRITE_PTR_W    = 6,
  parameter int          READ_PTR_W     = 5,
  parameter int          MAX_WRITE_WAIT = 4,
  parameter logic [21:0] BUFFER_STRIDE  = 22'h040000
) (
  input  logic                   sdram_clk,
  input  logic                   reset_n,
  input  logic [WRITE_PTR_W-1:0] write_used,
  output logic                   write_ack,
  input  logic [READ_PTR_W-1:0]  read_used,
  output logic                   read_push,
  input  logic                   write_frame_start,
  input  logic                   read_frame_start,
  output logic [1:0]             command,
  output logic [21:0]            data_address,
  input  logic                   data_read_valid,
  input  logic                   data_write_done,
  output logic                   write_buffer,
  output logic                   read_buffer
);
  localparam int          BEAT_W     = $clog2(BURST_LENGTH);
  localparam int          WAIT_W     = $clog2(MAX_WRITE_WAIT + 1);
  localparam int          READ_SPACE = 2**READ_PTR_W - 1;
  localparam logic [21:0] BL_W       = 22'(BURST_LENGTH);
  localparam logic [21:0] END_W      = 22'(VIDEO_END);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

  state_t            state;
  logic [21:0]       write_offset, read_offset;
  logic [BEAT_W-1:0] beat;
  logic [WAIT_W-1:0] write_wait;
  logic              last_complete, write_pending, read_pending;

  logic        read_ok, write_ok, go_write, go_read;
  logic        write_last, read_last, burst_end;
  logic        write_pend_now, read_pend_now, write_apply, read_apply;
  logic        write_wrap, read_wrap, write_toggle, write_buffer_nxt;
  logic [21:0] write_adv, read_adv, write_offset_nxt, read_offset_nxt;

  always_comb begin
    read_ok  = (32'(read_used) + BURST_LENGTH) <= READ_SPACE;
    write_ok = 32'(write_used) >= BURST_LENGTH;
    go_write = write_ok && ((32'(write_wait) >= MAX_WRITE_WAIT) || !read_ok);
    go_read  = read_ok && !go_write;

    write_last = (state == WRITE) && data_write_done && (32'(beat) == BURST_LENGTH - 1);
    read_last  = (state == READ) && data_read_valid && (32'(beat) == BURST_LENGTH - 1);
    burst_end  = write_last || read_last;

    // A frame-start pulse arriving while idle is folded straight into this cycle's grant.
    write_pend_now = write_pending || write_frame_start;
    read_pend_now  = read_pending || read_frame_start;
    write_apply    = write_pend_now && ((state == IDLE) || burst_end);
    read_apply     = read_pend_now && ((state == IDLE) || burst_end);

    write_wrap = write_last && ((write_offset + BL_W) == END_W);
    read_wrap  = read_last && ((read_offset + BL_W) == END_W);
    write_adv  = write_wrap ? 22'd0 : (write_last ? write_offset + BL_W : write_offset);
    read_adv   = read_wrap ? 22'd0 : (read_last ? read_offset + BL_W : read_offset);

    write_offset_nxt = write_apply ? 22'd0 : write_adv;
    read_offset_nxt  = read_apply ? 22'd0 : read_adv;
    // A restart only closes the frame if words were actually written into it.
    write_toggle     = write_wrap || (write_apply && (write_adv != 22'd0));
    write_buffer_nxt = write_buffer ^ write_toggle;

    read_push = (state == READ) && data_read_valid;
  end

  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      command       <= 2'd0;
      data_address  <= 22'd0;
      write_ack     <= 1'b0;
      beat          <= '0;
      write_wait    <= '0;
      write_offset  <= 22'd0;
      read_offset   <= 22'd0;
      write_buffer  <= 1'b0;
      read_buffer   <= 1'b0;
      last_complete <= 1'b0;
      write_pending <= 1'b0;
      read_pending  <= 1'b0;
    end else begin
      write_offset  <= write_offset_nxt;
      read_offset   <= read_offset_nxt;
      write_buffer  <= write_buffer_nxt;
      write_pending <= write_pend_now && !write_apply;
      read_pending  <= read_pend_now && !read_apply;
      if (write_toggle) last_complete <= write_buffer;
      if (read_wrap)    read_buffer   <= last_complete;
      write_ack <= 1'b0;
      case (state)
        IDLE: begin
          beat <= '0;
          if (go_write) begin
            state        <= WRITE;
            command      <= 2'd1;
            data_address <= write_offset_nxt + (write_buffer_nxt ? BUFFER_STRIDE : 22'd0);
            write_ack    <= 1'b1;
            write_wait   <= '0;
          end else if (go_read) begin
            state        <= READ;
            command      <= 2'd2;
            data_address <= read_offset_nxt + (read_buffer ? BUFFER_STRIDE : 22'd0);
            if (write_ok && (32'(write_wait) < MAX_WRITE_WAIT)) write_wait <= write_wait + 1'b1;
          end
        end
        WRITE: begin
          if (data_write_done) begin
            beat <= beat + 1'b1;
            if (write_last) begin
              state        <= IDLE;
              command      <= 2'd0;
              data_address <= 22'd0;
            end else begin
              write_ack <= 1'b1;
            end
          end
        end
        READ: begin
          if (data_read_valid) begin
            beat <= beat + 1'b1;
            if (read_last) begin
              state        <= IDLE;
              command      <= 2'd0;
              data_address <= 22'd0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          command <= 2'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_frame_scheduler.sv
// Bench for sdram_frame_scheduler: directed scenarios plus random traffic against a burst-level model.
module tb_sdram_frame_scheduler;
  localparam int          VE     = 256;
  localparam int          BL     = 8;
  localparam int          RPW    = 5;
  localparam int          MWW    = 4;
  localparam logic [21:0] STRIDE = 22'h040000;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [5:0]  write_used = 0;
  logic [4:0]  read_used = 31;
  logic        write_ack, read_push, write_buffer, read_buffer;
  logic        write_frame_start = 0, read_frame_start = 0;
  logic        data_read_valid = 0, data_write_done = 0;
  logic [1:0]  command;
  logic [21:0] data_address;

  sdram_frame_scheduler #(.VIDEO_END(VE), .BURST_LENGTH(BL), .WRITE_PTR_W(6), .READ_PTR_W(RPW),
                          .MAX_WRITE_WAIT(MWW), .BUFFER_STRIDE(STRIDE)) dut (
    .sdram_clk(clk), .reset_n(rst_n), .write_used(write_used), .write_ack(write_ack),
    .read_used(read_used), .read_push(read_push), .write_frame_start(write_frame_start),
    .read_frame_start(read_frame_start), .command(command), .data_address(data_address),
    .data_read_valid(data_read_valid), .data_write_done(data_write_done),
    .write_buffer(write_buffer), .read_buffer(read_buffer));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  // burst-level reference state
  int m_woff, m_roff, m_wait, beats, acks, pushes, prev_cmd, exp_next, burst_addr;
  bit m_wbuf, m_rbuf, m_last, m_wpend, m_rpend, m_wok, exp_valid;
  int grant_kind[$];
  int grant_addr[$];
  // stimulus controls
  int wu = 0, ru = 31, gap_mode = 0, cyc = 0;
  bit junk = 1, rand_mode = 0, pulse_w = 0, pulse_r = 0, pulse_w_on_last = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic predict();
    bit rok;
    m_wok = int'(write_used) >= BL;
    rok = ((2**RPW - 1) - int'(read_used)) >= BL;
    exp_next = (m_wait >= MWW && m_wok) ? 1 : rok ? 2 : m_wok ? 1 : 0;
    exp_valid = 1;
  endtask

  task automatic write_restart();
    if (m_woff != 0) begin
      m_last = m_wbuf;
      m_wbuf = !m_wbuf;
    end
    m_woff = 0;
  endtask

  task automatic model_step();
    int cmd = int'(command);
    if (prev_cmd != 0 && cmd == 0) begin
      if (prev_cmd == 1) begin
        chk("wr_beats", beats, BL);
        chk("wr_acks", acks, BL);
        m_woff += BL;
        if (m_woff == VE) begin m_woff = 0; m_last = m_wbuf; m_wbuf = !m_wbuf; end
      end else begin
        chk("rd_beats", beats, BL);
        chk("rd_pushes", pushes, BL);
        m_roff += BL;
        if (m_roff == VE) begin m_roff = 0; m_rbuf = m_last; end
      end
      if (m_wpend) begin write_restart(); m_wpend = 0; end
      if (m_rpend) begin m_roff = 0; m_rpend = 0; end
    end
    if (prev_cmd == 0 && exp_valid) chk("grant_kind", cmd, exp_next);
    if (prev_cmd != 0 && cmd != 0) chk("cmd_hold", cmd, prev_cmd);
    if (prev_cmd == 0 && cmd != 0) begin
      beats = 0; acks = 0; pushes = 0;
      burst_addr = (cmd == 1) ? m_woff + (m_wbuf ? int'(STRIDE) : 0) : m_roff + (m_rbuf ? int'(STRIDE) : 0);
      grant_kind.push_back(cmd);
      grant_addr.push_back(int'(data_address));
      if (cmd == 1) m_wait = 0;
      else if (m_wok && m_wait < MWW) m_wait++;
    end
    chk("address", data_address, (cmd != 0) ? burst_addr : 0);
    chk("read_push", read_push, (cmd == 2) && data_read_valid);
    if (cmd != 1) chk("ack_outside_write", write_ack, 0);
    chk("write_buffer", write_buffer, m_wbuf);
    chk("read_buffer", read_buffer, m_rbuf);
    if (cmd == 1) begin acks += int'(write_ack); beats += int'(data_write_done); end
    if (cmd == 2) begin pushes += int'(read_push); beats += int'(data_read_valid); end
    if (write_frame_start) begin if (cmd == 0) write_restart(); else m_wpend = 1; end
    if (read_frame_start) begin if (cmd == 0) m_roff = 0; else m_rpend = 1; end
    if (cmd == 0) predict();
    prev_cmd = cmd;
  endtask

  task automatic cycle();
    bit go, dv, dd, wf, rf;
    @(posedge clk);
    #1;
    cyc++;
    if (rand_mode) begin
      wu = $urandom_range(0, 63);
      ru = $urandom_range(0, 31);
      if ($urandom_range(0, 99) == 0) pulse_w = 1;
      if ($urandom_range(0, 99) == 0) pulse_r = 1;
    end
    case (gap_mode)
      0:       go = 1;
      1:       go = (cyc % 3 == 0);
      default: go = 1'($urandom_range(0, 1));
    endcase
    dv = (command == 2) ? go : (junk ? 1'($urandom_range(0, 1)) : 1'b0);
    dd = (command == 1) ? go : (junk ? 1'($urandom_range(0, 1)) : 1'b0);
    wf = pulse_w; pulse_w = 0;
    rf = pulse_r; pulse_r = 0;
    if (pulse_w_on_last && command == 1 && dd && beats == BL - 1) begin
      wf = 1;
      pulse_w_on_last = 0;
    end
    data_read_valid = dv; data_write_done = dd;
    write_frame_start = wf; read_frame_start = rf;
    write_used = 6'(wu); read_used = 5'(ru);
    @(negedge clk);
    model_step();
  endtask

  task automatic apply_reset();
    rst_n = 0;
    wu = 0; ru = 31;
    write_used = 0; read_used = 31;
    data_read_valid = 0; data_write_done = 0; write_frame_start = 0; read_frame_start = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_command", command, 0);
    chk("rst_address", data_address, 0);
    chk("rst_write_ack", write_ack, 0);
    chk("rst_read_push", read_push, 0);
    chk("rst_write_buffer", write_buffer, 0);
    chk("rst_read_buffer", read_buffer, 0);
    m_woff = 0; m_roff = 0; m_wait = 0; beats = 0; acks = 0; pushes = 0;
    m_wbuf = 0; m_rbuf = 0; m_last = 0; m_wpend = 0; m_rpend = 0;
    @(negedge clk);
    rst_n = 1;
    prev_cmd = 0;
    predict();
  endtask

  task automatic run_grants(input int n, input int budget);
    int target = grant_kind.size() + n;
    int k = 0;
    while (grant_kind.size() < target && k < budget) begin cycle(); k++; end
    chk("grant_count", grant_kind.size(), target);
  endtask

  task automatic run_idle(input int budget);
    int k = 0;
    while (command != 0 && k < budget) begin cycle(); k++; end
    chk("reach_idle", command, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, k, n;
    bit wb;
    apply_reset();

    // write only, read FIFO full: consecutive write bursts at 0 then 8
    wu = 8; ru = 31; i0 = grant_kind.size();
    run_grants(2, 100);
    chk("wonly_kind", grant_kind[i0], 1);
    chk("wonly_addr0", grant_addr[i0], 0);
    chk("wonly_addr1", grant_addr[i0 + 1], 8);
    wu = 0; run_idle(50);

    // read starving write: four reads, then the guaranteed write, then read again
    wu = 40; ru = 0; i0 = grant_kind.size();
    run_grants(6, 200);
    for (int i = 0; i < 6; i++) chk($sformatf("arb_seq%0d", i), grant_kind[i0 + i], (i == 4) ? 1 : 2);
    wu = 0; ru = 31; run_idle(50);

    // read beats with gaps, junk beats while idle
    gap_mode = 1; ru = 0;
    run_grants(3, 300);
    ru = 31; run_idle(100);
    gap_mode = 0;

    // two write frame wraps, then a read wrap picks up the last completed buffer
    wu = 8; ru = 31; k = 0;
    while (m_wbuf == 0 && k < 2000) begin cycle(); k++; end
    chk("wrap1_write_buffer", write_buffer, 1);
    run_grants(1, 50);
    chk("wrap1_next_addr", grant_addr[$], STRIDE);
    k = 0;
    while (m_wbuf == 1 && k < 2000) begin cycle(); k++; end
    chk("wrap2_write_buffer", write_buffer, 0);
    wu = 0; run_idle(50);
    ru = 0; k = 0;
    while (m_rbuf == 0 && k < 2000) begin cycle(); k++; end
    chk("read_wrap_buffer", read_buffer, 1);
    ru = 31; run_idle(50);

    // write frame restart mid-burst at offset 64
    wu = 8; k = 0;
    while (!(command == 1 && m_woff == 64) && k < 1000) begin cycle(); k++; end
    wb = m_wbuf;
    pulse_w = 1;
    run_grants(1, 50);
    chk("restart_addr", grant_addr[$], wb ? 0 : STRIDE);
    chk("restart_buffer", write_buffer, !wb);

    // restart pulse on the very beat that wraps the frame: one toggle only
    k = 0;
    while (!(command == 1 && m_woff == VE - BL) && k < 1000) begin cycle(); k++; end
    wb = m_wbuf;
    pulse_w_on_last = 1;
    run_grants(1, 50);
    chk("wrap_pulse_buffer", write_buffer, !wb);
    chk("wrap_pulse_addr", grant_addr[$], wb ? 0 : STRIDE);
    pulse_w_on_last = 0;

    // randomized traffic
    rand_mode = 1; gap_mode = 2;
    repeat (3000) cycle();
    rand_mode = 0; gap_mode = 0; wu = 0; ru = 31;
    run_idle(100);

    // asynchronous reset at beat 3 of a write burst
    wu = 8; k = 0;
    while (!(command == 1 && beats == 3) && k < 200) begin cycle(); k++; end
    chk("mid_write_reached", command, 1);
    #2;
    rst_n = 0;
    #1;
    chk("async_command", command, 0);
    chk("async_write_ack", write_ack, 0);
    chk("async_address", data_address, 0);
    apply_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin cycle(); n += int'(write_ack); end
    chk("post_reset_acks", n, 0);
    wu = 8; i0 = grant_kind.size();
    run_grants(1, 20);
    chk("post_reset_addr", grant_addr[i0], 0);
    wu = 0; run_idle(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
